led_scan_ctrl: RTL

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

---
 rtl/picoMIPS_package.sv | 39 +++
 rtl/led_scan_ctrl_7seg.sv | 39 +++
 rtl/led_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/picoMIPS_package.sv
// Shared picoMIPS definitions: datapath width, nibble size, the display
// scanner state type and nibble helper functions used by led_scan_ctrl.
package picoMIPS_package;

    localparam int DATA_WIDTH = 8;
    localparam int NIBBLE     = 4;

    typedef enum logic [1:0] {
        BLANK = 2'b00,
        SCAN  = 2'b01,
        GUARD = 2'b10
    } scan_state_t;

    // Extract nibble idx of a data word (nibble 0 = least significant).
    function automatic logic [NIBBLE-1:0] nibble_at(
        input logic [DATA_WIDTH-1:0] value,
        input int                    idx
    );
        return value[idx*NIBBLE +: NIBBLE];
    endfunction

    // True when nibbles idx..ndigits-1 of value are all zero, i.e. digit idx
    // and everything to its left would be a leading zero.
    function automatic logic upper_zero(
        input logic [DATA_WIDTH-1:0] value,
        input int                    idx,
        input int                    ndigits
    );
        logic zero;
        zero = 1'b1;
        for (int i = 0; i < DATA_WIDTH / NIBBLE; i++) begin
            if ((i >= idx) && (i < ndigits) && (value[i*NIBBLE +: NIBBLE] != 4'h0)) begin
                zero = 1'b0;
            end
        end
        return zero;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_7seg.sv
// Hex to seven-segment decoder (segments active high, bit order gfedcba).
// With en low every segment is off.
module led_7seg
    import picoMIPS_package::*;
(
    input  logic              en,
    input  logic [NIBBLE-1:0] val,
    output logic [6:0]        seg
);

    // Combinational glyph lookup for one hex digit.
    always_comb begin
        seg = 7'h00;
        if (en) begin
            case (val)
                4'h0:    seg = 7'h3F;
                4'h1:    seg = 7'h06;
                4'h2:    seg = 7'h5B;
                4'h3:    seg = 7'h4F;
                4'h4:    seg = 7'h66;
                4'h5:    seg = 7'h6D;
                4'h6:    seg = 7'h7D;
                4'h7:    seg = 7'h07;
                4'h8:    seg = 7'h7F;
                4'h9:    seg = 7'h6F;
                4'hA:    seg = 7'h77;
                4'hB:    seg = 7'h7C;
                4'hC:    seg = 7'h39;
                4'hD:    seg = 7'h5E;
                4'hE:    seg = 7'h79;
                4'hF:    seg = 7'h71;
                default: seg = 7'h00;
            endcase
        end else begin
            seg = 7'h00;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed seven-segment display scanner. One shared led_7seg decoder is
// time-shared across NDIGITS digits; each digit slot lasts PRESCALE cycles
// followed by one dark GUARD cycle to avoid ghosting. New values are staged in
// a pending register and only copied to the display at a frame wrap.
// Optional feature: define LED_ZERO_SUPPRESS_EN to blank leading zero digits.
module led_scan_ctrl
    import picoMIPS_package::*;
#(
    parameter int NDIGITS  = DATA_WIDTH / NIBBLE,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic [6:0]            LED,
    output logic [NDIGITS-1:0]    digit_en
);

    localparam int DW = (NDIGITS  > 1) ? $clog2(NDIGITS)  : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    if ((NDIGITS * NIBBLE > DATA_WIDTH) || (DATA_WIDTH % NIBBLE != 0) || (PRESCALE < 1)) begin : g_bad_cfg
        $error("led_scan_ctrl: NDIGITS*4 must fit DATA_WIDTH (a multiple of 4) and PRESCALE >= 1");
    end

    scan_state_t           state_r;
    logic [DW-1:0]         digit_r;
    logic [PW-1:0]         presc_r;
    logic [DATA_WIDTH-1:0] pending_r;
    logic [DATA_WIDTH-1:0] display_r;
    logic                  ready_r;
    logic [NDIGITS-1:0]    digit_en_r;
    logic                  dec_en_r;
    logic [NIBBLE-1:0]     dec_val_r;

    logic                  wrap_s;
    logic [DW-1:0]         next_digit_s;
    logic [DATA_WIDTH-1:0] next_disp_s;
    logic                  guard_lit_s;
    logic [NIBBLE-1:0]     guard_val_s;

    function automatic logic [NDIGITS-1:0] onehot(input logic [DW-1:0] d);
        return NDIGITS'(1) << d;
    endfunction

    // Values the GUARD cycle hands to the next SCAN slot: next digit index,
    // the frame's display value (pending wins at a wrap) and its visibility.
    always_comb begin
        wrap_s       = (digit_r == DW'(NDIGITS - 1));
        next_digit_s = wrap_s ? {DW{1'b0}} : (digit_r + {{(DW-1){1'b0}}, 1'b1});
        next_disp_s  = (wrap_s && !ready_r) ? pending_r : display_r;
        guard_val_s  = nibble_at(next_disp_s, int'(next_digit_s));
`ifdef LED_ZERO_SUPPRESS_EN
        guard_lit_s  = (next_digit_s == {DW{1'b0}}) ||
                       !upper_zero(next_disp_s, int'(next_digit_s), NDIGITS);
`else
        guard_lit_s  = 1'b1;
`endif
    end

    // Scan FSM: load handshake, slot timing, frame-wrap display update and
    // registered digit/decoder drive for the cycle being entered.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_r    <= BLANK;
            digit_r    <= {DW{1'b0}};
            presc_r    <= {PW{1'b0}};
            pending_r  <= {DATA_WIDTH{1'b0}};
            display_r  <= {DATA_WIDTH{1'b0}};
            ready_r    <= 1'b1;
            digit_en_r <= {NDIGITS{1'b0}};
            dec_en_r   <= 1'b0;
            dec_val_r  <= {NIBBLE{1'b0}};
        end else begin
            case (state_r)
                BLANK: begin
                    if (!ready_r) begin
                        display_r  <= pending_r;
                        ready_r    <= 1'b1;
                        digit_r    <= {DW{1'b0}};
                        presc_r    <= {PW{1'b0}};
                        state_r    <= SCAN;
                        digit_en_r <= onehot({DW{1'b0}});
                        dec_en_r   <= 1'b1;
                        dec_val_r  <= nibble_at(pending_r, 0);
                    end else if (load) begin
                        pending_r  <= data_in;
                        ready_r    <= 1'b0;
                        digit_en_r <= {NDIGITS{1'b0}};
                        dec_en_r   <= 1'b0;
                    end else begin
                        digit_en_r <= {NDIGITS{1'b0}};
                        dec_en_r   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (load && ready_r) begin
                        pending_r <= data_in;
                        ready_r   <= 1'b0;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (presc_r == PW'(PRESCALE - 1)) begin
                        presc_r    <= {PW{1'b0}};
                        state_r    <= GUARD;
                        digit_en_r <= {NDIGITS{1'b0}};
                        dec_en_r   <= 1'b0;
                    end else begin
                        presc_r    <= presc_r + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                GUARD: begin
                    state_r <= SCAN;
                    digit_r <= next_digit_s;
                    presc_r <= {PW{1'b0}};
                    if (wrap_s && !ready_r) begin
                        display_r <= pending_r;
                        ready_r   <= 1'b1;
                    end else if (load && ready_r) begin
                        pending_r <= data_in;
                        ready_r   <= 1'b0;
                    end else begin
                        display_r <= display_r;
                    end
                    digit_en_r <= guard_lit_s ? onehot(next_digit_s) : {NDIGITS{1'b0}};
                    dec_en_r   <= guard_lit_s;
                    dec_val_r  <= guard_val_s;
                end
                default: begin
                    state_r    <= BLANK;
                    digit_en_r <= {NDIGITS{1'b0}};
                    dec_en_r   <= 1'b0;
                    ready_r    <= 1'b1;
                end
            endcase
        end
    end

    led_7seg u_led_7seg (
        .en  (dec_en_r),
        .val (dec_val_r),
        .seg (LED)
    );

    assign ready    = ready_r;
    assign digit_en = digit_en_r;

endmodule
